// File: rtl/rps4_pkg.sv
// Shared types and helpers for the rps4 arbiter requester side.
package rps4_pkg;

  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;

  typedef logic [CHW-1:0] ch_t;
  typedef logic [NCH-1:0] req_vec_t;

  // 1 when zero or exactly one bit of v is set.
  function automatic logic onehot0(input req_vec_t v);
    return (v & (v - req_vec_t'(1))) == '0;
  endfunction

  // Index of the set bit in a one-hot vector; 0 when none is set.
  function automatic ch_t onehot_index(input req_vec_t v);
    ch_t idx;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (v[i]) idx = ch_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rps4_chan_fifo.sv
// Single-channel circular FIFO with head-of-queue data and entry count.
module rps4_chan_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned DW    = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rps4_requester.sv
// Requester agent: per-channel FIFOs feeding the rps4 arbiter, grant-driven pop
// with a registered output, and a sticky grant protocol checker.
module rps4_requester
  import rps4_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned DW    = 8,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [CHW-1:0]    push_ch,
  input  logic [DW-1:0]     push_data,
  output logic              push_ready,
  input  logic              hold,
  output logic [NCH-1:0]    req,
  output logic              en,
  input  logic [NCH-1:0]    gnt,
  output logic              out_valid,
  output logic [CHW-1:0]    out_ch,
  output logic [DW-1:0]     out_data,
  output logic [NCH*CW-1:0] occupancy,
  output logic              err
);

  logic [CW-1:0] cnt  [NCH];
  logic [DW-1:0] head [NCH];
  logic [NCH-1:0] full;
  req_vec_t       pop_vec;
  logic           illegal;
  ch_t            sel;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    rps4_chan_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_valid & push_ready & (push_ch == ch_t'(g))),
      .push_data (push_data),
      .pop       (pop_vec[g]),
      .head      (head[g]),
      .count     (cnt[g])
    );
    assign occupancy[g*CW +: CW] = cnt[g];
    assign req[g]  = cnt[g] != '0;
    assign full[g] = cnt[g] == CW'(DEPTH);
  end

  assign push_ready = ~full[push_ch];
  assign en         = ~hold & (|req);

  // A grant is honoured only when it is one-hot, on a requesting lane, with en high.
  always_comb begin
    illegal = '0;
    pop_vec = '0;
    illegal = (|gnt) & (~onehot0(gnt) | (|(gnt & ~req)) | ~en);
    if (!illegal) pop_vec = gnt & req & {NCH{en}};
    sel = onehot_index(pop_vec);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= |pop_vec;
      if (|pop_vec) begin
        out_ch   <= sel;
        out_data <= head[sel];
      end
      err <= err | illegal;
    end
  end

endmodule

// File: tb/tb_rps4_requester.sv
// Randomized and directed bench for rps4_requester against a queue-based model.
module tb_rps4_requester;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        push_valid = 1'b0;
  logic [1:0]  push_ch = '0;
  logic [7:0]  push_data = '0;
  logic        push_ready;
  logic        hold = 1'b0;
  logic [3:0]  req;
  logic        en;
  logic [3:0]  gnt = '0;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [7:0]  out_data;
  logic [11:0] occupancy;
  logic        err;

  rps4_requester #(.DEPTH(DEPTH), .DW(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_valid),
    .push_ch    (push_ch),
    .push_data  (push_data),
    .push_ready (push_ready),
    .hold       (hold),
    .req        (req),
    .en         (en),
    .gnt        (gnt),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .err        (err)
  );

  always #5 clock = ~clock;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: one queue per channel plus expected output registers.
  logic [7:0] q [4][$];
  logic       m_err;
  logic       m_ov;
  logic [1:0] m_ch;
  logic [7:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_req();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = q[i].size() != 0;
    return r;
  endfunction

  task automatic check_state();
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_ch", 32'(out_ch), 32'(m_ch));
    check("out_data", 32'(out_data), 32'(m_data));
    check("err", 32'(err), 32'(m_err));
    for (int i = 0; i < 4; i++)
      check("occupancy", 32'(occupancy[3*i +: 3]), 32'(q[i].size()));
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check state.
  task automatic step(input logic pv, input logic [1:0] pc, input logic [7:0] pd,
                      input logic h, input logic [3:0] g);
    logic [3:0] r;
    logic       e, rdy, bad;
    int         idx;
    push_valid = pv; push_ch = pc; push_data = pd; hold = h; gnt = g;
    r   = m_req();
    e   = !h && (r != 0);
    rdy = q[pc].size() < DEPTH;
    #1;
    check("req", 32'(req), 32'(r));
    check("en", 32'(en), 32'(e));
    check("push_ready", 32'(push_ready), 32'(rdy));
    bad = (g != 0) && (($countones(g) > 1) || ((g & ~r) != 0) || !e);
    @(posedge clock);
    m_ov = 1'b0;
    if (g != 0 && !bad) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (g[i]) idx = i;
      m_ov   = 1'b1;
      m_ch   = 2'(idx);
      m_data = q[idx].pop_front();
    end
    if (pv && rdy) q[pc].push_back(pd);
    m_err = m_err | bad;
    @(negedge clock);
    push_valid = 1'b0; gnt = '0;
    check_state();
  endtask

  task automatic do_reset();
    push_valid = 1'b0; hold = 1'b0; gnt = '0;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) q[i].delete();
    m_err = 1'b0; m_ov = 1'b0; m_ch = '0; m_data = '0;
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_state();
  endtask

  initial begin
    logic [3:0] r, g;
    int rr, c, k;
    logic found;

    do_reset();

    // Reset mid-traffic
    for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 8'(8'h30 + i), 1'b0, 4'b0000);
    check("mid_occ2", 32'(occupancy[8:6]), 32'd3);
    do_reset();

    // Push then grant
    step(1'b1, 2'd0, 8'hA5, 1'b0, 4'b0000);
    check("pg_req", 32'(req), 32'b0001);
    step(1'b0, 2'd0, 8'h00, 1'b0, 4'b0001);
    check("pg_ov", 32'(out_valid), 32'd1);
    check("pg_ch", 32'(out_ch), 32'd0);
    check("pg_data", 32'(out_data), 32'hA5);
    check("pg_req0", 32'(req), 32'd0);

    // Full channel
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 8'(8'h40 + i), 1'b0, 4'b0000);
    push_ch = 2'd1;
    #1;
    check("full_ready", 32'(push_ready), 32'd0);
    step(1'b1, 2'd1, 8'h44, 1'b0, 4'b0000);
    check("full_drop", 32'(occupancy[5:3]), 32'd4);
    step(1'b1, 2'd1, 8'h45, 1'b0, 4'b0010);
    check("full_popocc", 32'(occupancy[5:3]), 32'd3);
    check("full_popdata", 32'(out_data), 32'h40);

    // Rotation with a round-robin arbiter model
    do_reset();
    for (int k2 = 0; k2 < 2; k2++)
      for (int ch = 0; ch < 4; ch++)
        step(1'b1, 2'(ch), 8'(16 * ch + k2), 1'b0, 4'b0000);
    rr = 0;
    for (int j = 0; j < 8; j++) begin
      r = m_req(); g = '0; found = 1'b0; c = 0;
      for (k = 0; k < 4; k++) begin
        if (!found && r[(rr + k) % 4]) begin
          c = (rr + k) % 4; g[c] = 1'b1; found = 1'b1;
        end
      end
      rr = (c + 1) % 4;
      step(1'b0, 2'd0, 8'h00, 1'b0, g);
      check("rot_ch", 32'(out_ch), 32'(j % 4));
      check("rot_data", 32'(out_data), 32'(16 * (j % 4) + j / 4));
    end

    // hold
    do_reset();
    for (int ch = 0; ch < 4; ch++) step(1'b1, 2'(ch), 8'(8'h60 + ch), 1'b0, 4'b0000);
    hold = 1'b1;
    #1;
    check("hold_en", 32'(en), 32'd0);
    check("hold_req", 32'(req), 32'hF);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 4'b0000);
    check("hold_ov", 32'(out_valid), 32'd0);
    check("hold_err", 32'(err), 32'd0);
    step(1'b0, 2'd0, 8'h00, 1'b0, 4'b0100);
    check("hold_resume", 32'(out_valid), 32'd1);
    check("hold_data", 32'(out_data), 32'h62);

    // Randomized traffic with legal grants and occasional mid-run reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic h;
      int idx;
      if ($urandom_range(0, 150) == 0) do_reset();
      h = ($urandom_range(0, 4) == 0);
      r = m_req(); g = '0;
      if (!h && r != 0 && $urandom_range(0, 2) != 0) begin
        idx = $urandom_range(0, 3);
        while (!r[idx]) idx = (idx + 1) % 4;
        g[idx] = 1'b1;
      end
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), h, g);
    end

    // Protocol check: multiple grant bits
    do_reset();
    step(1'b1, 2'd0, 8'h11, 1'b0, 4'b0000);
    step(1'b1, 2'd1, 8'h22, 1'b0, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 1'b0, 4'b0011);
    check("pc_err", 32'(err), 32'd1);
    check("pc_nopop", 32'(out_valid), 32'd0);
    step(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
    check("pc_sticky", 32'(err), 32'd1);

    // Protocol check: grant on a non-requesting lane
    do_reset();
    step(1'b1, 2'd0, 8'h33, 1'b0, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 1'b0, 4'b0100);
    check("pc2_err", 32'(err), 32'd1);
    check("pc2_occ0", 32'(occupancy[2:0]), 32'd1);

    // Protocol check: grant while hold suppresses en
    do_reset();
    step(1'b1, 2'd3, 8'h77, 1'b0, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 1'b1, 4'b1000);
    check("pc3_err", 32'(err), 32'd1);
    check("pc3_nopop", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
